// File: rtl/sync_fifo_pkg.sv
// Shared status codes and the occupancy-to-status decode for the FIFO core.
package sync_fifo_pkg;

    localparam logic [2:0] ST_EMPTY = 3'd0;
    localparam logic [2:0] ST_Q1    = 3'd1;
    localparam logic [2:0] ST_Q2    = 3'd2;
    localparam logic [2:0] ST_Q3    = 3'd3;
    localparam logic [2:0] ST_Q4    = 3'd4;
    localparam logic [2:0] ST_FULL  = 3'd5;

    // Quarter bands are inclusive at the top; FULL only at exactly depth.
    function automatic logic [2:0] status_of(input logic [31:0] cnt, input logic [31:0] depth);
        logic [31:0] q;
        logic [2:0]  st;
        q = depth >> 2;
        if (cnt == 32'd0)
            st = ST_EMPTY;
        else if (cnt <= q)
            st = ST_Q1;
        else if (cnt <= (q << 1))
            st = ST_Q2;
        else if (cnt <= (q + (q << 1)))
            st = ST_Q3;
        else if (cnt < depth)
            st = ST_Q4;
        else
            st = ST_FULL;
        return st;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read-first read port.
module fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Read samples the array before this edge's write lands (read-first).
    always_ff @(posedge clk) begin
        if (rst)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO core: pointers, occupancy count, accept logic, status code
// and one-cycle overflow/underflow pulses around a read-first storage array.
module sync_fifo_core
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [2:0]            fifo_status,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // A pop frees a slot this same edge, so a push into a full FIFO may proceed.
    assign w_pop   = rd_en && !w_empty;
    assign w_push  = wr_en && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
            r_rd_valid  <= w_pop;
            r_overflow  <= wr_en && !w_push;
            r_underflow <= rd_en && !w_pop;
        end
    end

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_push),
        .i_waddr(r_wr_ptr),
        .i_wdata(write_data),
        .i_re   (w_pop),
        .i_raddr(r_rd_ptr),
        .o_rdata(rd_data)
    );

    assign fifo_status = status_of(32'(r_count), 32'(DEPTH));
    assign count       = r_count;
    assign rd_valid    = r_rd_valid;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_sync_fifo_core.sv
// Randomised and directed bench for sync_fifo_core against a queue-based model.
module tb_sync_fifo_core;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] write_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [2:0]    fifo_status;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    sync_fifo_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .write_data (write_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_status(fifo_status),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_rd_data;
    logic          m_rd_valid;
    logic          m_ovf;
    logic          m_unf;
    int            n_push_total;
    int            max_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_status(input int c);
        if (c == 0) return 32'd0;
        if (c == DEPTH) return 32'd5;
        return 32'((c - 1) / (DEPTH / 4) + 1);
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare just after.
    task automatic cycle(input logic r, input logic w, input logic [DW-1:0] d, input logic p);
        bit full, pop_ok, push_ok;
        @(negedge clk);
        rst = r; wr_en = w; write_data = d; rd_en = p;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            full    = (m_q.size() == DEPTH);
            pop_ok  = p && (m_q.size() != 0);
            push_ok = w && (!full || pop_ok);
            if (pop_ok) m_rd_data = m_q.pop_front();
            if (push_ok) begin
                m_q.push_back(d);
                n_push_total++;
            end
            m_rd_valid = pop_ok;
            m_ovf = w && !push_ok;
            m_unf = p && !pop_ok;
        end
        if (m_q.size() > max_cnt) max_cnt = m_q.size();
        #1;
        check("count", 32'(count), 32'(m_q.size()));
        check("status", 32'(fifo_status), exp_status(m_q.size()));
        check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        check("rd_data", rd_data, m_rd_data);
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; write_data = '0; rd_en = 1'b0;
        n_push_total = 0; max_cnt = 0;
        m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

        // Power-on reset
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);

        // Reset mid-stream at count 7
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, $urandom, 1'b0);
        check("pre_rst_count", 32'(count), 32'd7);
        cycle(1'b1, 1'b1, 32'hDEAD, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b0);
        check("rst_wr_ptr", 32'(dut.r_wr_ptr), 32'd0);
        check("rst_rd_ptr", 32'(dut.r_rd_ptr), 32'd0);
        check("rst_count", 32'(count), 32'd0);

        // Fill 1..16 then one overflowing push
        for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b1, 32'(i), 1'b0);
        check("fill_full_status", 32'(fifo_status), 32'd5);
        cycle(1'b0, 1'b1, 32'h77, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        cycle(1'b0, 1'b0, '0, 1'b0);
        check("ovf_clear", 32'(overflow), 32'd0);

        // Drain 16, then one underflowing pop
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            check("drain_data", rd_data, 32'(i));
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        check("unf_pulse", 32'(underflow), 32'd1);
        check("unf_hold", rd_data, 32'h10);

        // Full with simultaneous push+pop
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
        cycle(1'b0, 1'b1, 32'hAA, 1'b1);
        check("fullpp_data", rd_data, 32'h100);
        check("fullpp_count", 32'(count), 32'd16);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        check("fullpp_last", rd_data, 32'hAA);

        // Empty with simultaneous push+pop
        cycle(1'b0, 1'b1, 32'h55, 1'b1);
        check("emptypp_unf", 32'(underflow), 32'd1);
        check("emptypp_count", 32'(count), 32'd1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check("emptypp_data", rd_data, 32'h55);

        // Random traffic long enough for several pointer wraps
        n_push_total = 0;
        max_cnt = 0;
        for (int i = 0; i < 240; i++) begin
            int bias;
            bias = (i / 40) % 2;
            cycle(1'b0, ($urandom_range(0, 3) < (bias ? 1 : 3)), $urandom,
                  ($urandom_range(0, 3) < (bias ? 3 : 1)));
        end
        check("wraps_ge_2", 32'(n_push_total >= 2 * DEPTH), 32'd1);
        check("max_cnt_le_depth", 32'(max_cnt <= DEPTH), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
